// File: rtl/instr_fetch_unit.sv
// Instruction fetch unit: owns the PC, fetches over req/gnt/rvalid into a one-word buffer, loads IR on LoadIR.
// Optional misaligned-PC check enabled by defining FETCH_MISALIGN_CHECK_EN.
module instr_fetch_unit #(
  parameter int unsigned     PC_W        = 64,
  parameter logic [PC_W-1:0] RESET_PC    = '0,
  parameter int unsigned     TIMEOUT_CYC = 255
) (
  input  logic            clock,
  input  logic            reset,
  input  logic            PCWrite,
  input  logic [PC_W-1:0] pc_in,
  input  logic            LoadIR,
  output logic            imem_req,
  output logic [PC_W-1:0] imem_addr,
  input  logic            imem_gnt,
  input  logic            imem_rvalid,
  input  logic [31:0]     imem_rdata,
  output logic [PC_W-1:0] pc,
  output logic [31:0]     Instr31_0,
  output logic [6:0]      opcode,
  output logic [PC_W-1:0] ir_pc,
  output logic            ir_valid,
  output logic            fetch_stall,
  output logic            fetch_err,
  output logic            fetch_fault,
  output logic [1:0]      dbg_state
);

  // Handshake: a request transfers when imem_req && imem_gnt are both high at a rising edge;
  // exactly one imem_rvalid pulse answers each transferred request, never in the same cycle.
  typedef enum logic [1:0] {
    S_REQ  = 2'd0,
    S_WAIT = 2'd1,
    S_FULL = 2'd2
  } state_t;

  localparam logic [7:0] TIMEOUT_LAST = 8'(TIMEOUT_CYC - 1);

  state_t          state_q, state_d;
  logic [PC_W-1:0] pc_q, pc_d;
  logic [31:0]     buf_q, buf_d;
  logic [PC_W-1:0] buf_pc_q, buf_pc_d;
  logic [31:0]     ir_q, ir_d;
  logic [PC_W-1:0] ir_pc_q, ir_pc_d;
  logic            ir_valid_q, ir_valid_d;
  logic            drop_q, drop_d;
  logic [7:0]      cnt_q, cnt_d;
  logic            err_q, err_d;
  logic            fault_q, fault_d;
  logic            misaligned;

  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    buf_d       = buf_q;
    buf_pc_d    = buf_pc_q;
    ir_d        = ir_q;
    ir_pc_d     = ir_pc_q;
    ir_valid_d  = ir_valid_q;
    drop_d      = drop_q;
    cnt_d       = cnt_q;
    err_d       = err_q;
    fault_d     = fault_q;
    imem_req    = 1'b0;
    fetch_stall = 1'b0;
`ifdef FETCH_MISALIGN_CHECK_EN
    misaligned  = (pc_q[1:0] != 2'b00);
`else
    misaligned  = 1'b0;
`endif

    if (PCWrite) pc_d = pc_in;

    case (state_q)
      S_REQ: begin
        imem_req = !misaligned;
        if (misaligned) fault_d = 1'b1;
        if (imem_req && imem_gnt) begin
          state_d = S_WAIT;
          cnt_d   = 8'd0;
          // A PC change in the grant cycle means the granted address is stale.
          drop_d  = PCWrite;
        end
      end
      S_WAIT: begin
        cnt_d = cnt_q + 8'd1;
        if (PCWrite) drop_d = 1'b1;
        if (imem_rvalid) begin
          if (drop_q || PCWrite) begin
            drop_d  = 1'b0;
            state_d = S_REQ;
          end else begin
            buf_d    = imem_rdata;
            buf_pc_d = pc_q;
            state_d  = S_FULL;
          end
        end else if (cnt_q == TIMEOUT_LAST) begin
          err_d   = 1'b1;
          drop_d  = 1'b0;
          state_d = S_REQ;
        end
      end
      S_FULL: begin
        if (PCWrite) state_d = S_REQ;
      end
      default: state_d = S_REQ;
    endcase

    // The buffer is not consumed, so repeated LoadIR reloads the same word.
    if (LoadIR) begin
      if (state_q == S_FULL) begin
        ir_d       = buf_q;
        ir_pc_d    = buf_pc_q;
        ir_valid_d = 1'b1;
      end else begin
        fetch_stall = 1'b1;
      end
    end

    if (PCWrite && (pc_in[1:0] == 2'b00)) fault_d = 1'b0;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q    <= S_REQ;
      pc_q       <= RESET_PC;
      buf_q      <= '0;
      buf_pc_q   <= '0;
      ir_q       <= '0;
      ir_pc_q    <= '0;
      ir_valid_q <= 1'b0;
      drop_q     <= 1'b0;
      cnt_q      <= '0;
      err_q      <= 1'b0;
      fault_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      buf_q      <= buf_d;
      buf_pc_q   <= buf_pc_d;
      ir_q       <= ir_d;
      ir_pc_q    <= ir_pc_d;
      ir_valid_q <= ir_valid_d;
      drop_q     <= drop_d;
      cnt_q      <= cnt_d;
      err_q      <= err_d;
      fault_q    <= fault_d;
    end
  end

  assign imem_addr = pc_q;
  assign pc        = pc_q;
  assign Instr31_0 = ir_q;
  assign opcode    = ir_q[6:0];
  assign ir_pc     = ir_pc_q;
  assign ir_valid  = ir_valid_q;
  assign fetch_err = err_q;
  assign dbg_state = state_q;
`ifdef FETCH_MISALIGN_CHECK_EN
  assign fetch_fault = fault_q;
`else
  assign fetch_fault = 1'b0;
`endif

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed self-checking bench for instr_fetch_unit; the misalignment section runs only
// when FETCH_MISALIGN_CHECK_EN is defined.
module tb_instr_fetch_unit;

  localparam int PC_W = 64;

  logic            clock = 1'b0;
  logic            reset;
  logic            PCWrite;
  logic [PC_W-1:0] pc_in;
  logic            LoadIR;
  logic            imem_req;
  logic [PC_W-1:0] imem_addr;
  logic            imem_gnt;
  logic            imem_rvalid;
  logic [31:0]     imem_rdata;
  logic [PC_W-1:0] pc;
  logic [31:0]     Instr31_0;
  logic [6:0]      opcode;
  logic [PC_W-1:0] ir_pc;
  logic            ir_valid;
  logic            fetch_stall;
  logic            fetch_err;
  logic            fetch_fault;
  logic [1:0]      dbg_state;

  int total = 0;
  int bad   = 0;

  // clock / reset block
  always #5 clock = ~clock;

  instr_fetch_unit #(.PC_W(PC_W), .RESET_PC(64'h0), .TIMEOUT_CYC(255)) dut (
    .clock(clock), .reset(reset), .PCWrite(PCWrite), .pc_in(pc_in), .LoadIR(LoadIR),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_gnt(imem_gnt),
    .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata), .pc(pc),
    .Instr31_0(Instr31_0), .opcode(opcode), .ir_pc(ir_pc), .ir_valid(ir_valid),
    .fetch_stall(fetch_stall), .fetch_err(fetch_err), .fetch_fault(fetch_fault),
    .dbg_state(dbg_state)
  );

  // driver tasks: inputs change 1 time unit after the rising edge
  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic idle_inputs();
    PCWrite     = 1'b0;
    pc_in       = '0;
    LoadIR      = 1'b0;
    imem_gnt    = 1'b0;
    imem_rvalid = 1'b0;
    imem_rdata  = '0;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: observed=no_finish expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    bit seen;
    idle_inputs();
    reset = 1'b1;
    tick(); tick();
    chk("rst_pc", pc, 64'h0);
    chk("rst_ir", Instr31_0, 32'h0);
    chk("rst_ir_valid", ir_valid, 1'b0);
    chk("rst_err", fetch_err, 1'b0);
    chk("rst_fault", fetch_fault, 1'b0);
    reset = 1'b0;
    settle();
    chk("first_req", imem_req, 1'b1);
    chk("first_addr", imem_addr, 64'h0);

    // fetch word@0: immediate grant, data two cycles later
    imem_gnt = 1'b1; tick(); imem_gnt = 1'b0;
    settle();
    chk("wait_no_req", imem_req, 1'b0);
    chk("wait_state", dbg_state, 2'd1);
    tick();
    imem_rvalid = 1'b1; imem_rdata = 32'h00A00093; tick(); imem_rvalid = 1'b0;
    LoadIR = 1'b1; settle();
    chk("full_no_stall", fetch_stall, 1'b0);
    tick(); LoadIR = 1'b0;
    chk("ir0", Instr31_0, 32'h00A00093);
    chk("opcode0", opcode, 7'h13);
    chk("ir_pc0", ir_pc, 64'h0);
    chk("ir_valid0", ir_valid, 1'b1);

    // latch then advance
    LoadIR = 1'b1; PCWrite = 1'b1; pc_in = 64'h4; tick(); idle_inputs();
    settle();
    chk("adv_pc", pc, 64'h4);
    chk("adv_ir", Instr31_0, 32'h00A00093);
    chk("adv_req", imem_req, 1'b1);
    chk("adv_addr", imem_addr, 64'h4);
    imem_gnt = 1'b1; tick(); imem_gnt = 1'b0;
    LoadIR = 1'b1; settle();
    chk("stall_wait", fetch_stall, 1'b1);
    tick(); LoadIR = 1'b0;
    chk("stall_ir_kept", Instr31_0, 32'h00A00093);

    // redirect while waiting for addr 4
    PCWrite = 1'b1; pc_in = 64'h40; tick(); idle_inputs();
    imem_rvalid = 1'b1; imem_rdata = 32'hDEAD0004; tick(); imem_rvalid = 1'b0;
    settle();
    chk("redir_req", imem_req, 1'b1);
    chk("redir_addr", imem_addr, 64'h40);
    imem_gnt = 1'b1; tick(); imem_gnt = 1'b0;
    imem_rvalid = 1'b1; imem_rdata = 32'h04000513; tick(); imem_rvalid = 1'b0;
    LoadIR = 1'b1; tick(); LoadIR = 1'b0;
    chk("redir_ir", Instr31_0, 32'h04000513);
    chk("redir_ir_pc", ir_pc, 64'h40);

    // PCWrite coincident with grant
    PCWrite = 1'b1; pc_in = 64'h44; tick(); idle_inputs();
    PCWrite = 1'b1; pc_in = 64'h80; imem_gnt = 1'b1; tick(); idle_inputs();
    imem_rvalid = 1'b1; imem_rdata = 32'h11111111; tick(); imem_rvalid = 1'b0;
    settle();
    chk("gntpc_req", imem_req, 1'b1);
    chk("gntpc_addr", imem_addr, 64'h80);
    chk("gntpc_ir_kept", Instr31_0, 32'h04000513);
    imem_gnt = 1'b1; tick(); imem_gnt = 1'b0;
    imem_rvalid = 1'b1; imem_rdata = 32'h22222213; tick(); imem_rvalid = 1'b0;
    LoadIR = 1'b1; tick(); LoadIR = 1'b0;
    chk("gntpc_ir", Instr31_0, 32'h22222213);
    chk("gntpc_ir_pc", ir_pc, 64'h80);
    chk("gntpc_opcode", opcode, 7'h13);

    // memory timeout
    PCWrite = 1'b1; pc_in = 64'h100; tick(); idle_inputs();
    imem_gnt = 1'b1; tick(); imem_gnt = 1'b0;
    repeat (200) tick();
    chk("to_early", fetch_err, 1'b0);
    seen = 1'b0;
    for (int i = 0; i < 100 && !seen; i++) begin
      tick();
      seen = fetch_err;
    end
    chk("to_err", fetch_err, 1'b1);
    chk("to_reissue", imem_req, 1'b1);
    chk("to_addr", imem_addr, 64'h100);
    tick();
    chk("to_sticky", fetch_err, 1'b1);
    reset = 1'b1; tick(); reset = 1'b0;
    settle();
    chk("rst2_err", fetch_err, 1'b0);
    chk("rst2_pc", pc, 64'h0);
    chk("rst2_ir_valid", ir_valid, 1'b0);

    // stray rvalid in REQ is ignored
    imem_rvalid = 1'b1; imem_rdata = 32'h33333333; tick(); imem_rvalid = 1'b0;
    settle();
    chk("stray_req", imem_req, 1'b1);
    chk("stray_state", dbg_state, 2'd0);

`ifdef FETCH_MISALIGN_CHECK_EN
    PCWrite = 1'b1; pc_in = 64'h6; tick(); idle_inputs();
    settle();
    chk("mis_no_req", imem_req, 1'b0);
    tick();
    chk("mis_fault", fetch_fault, 1'b1);
    LoadIR = 1'b1; settle();
    chk("mis_stall", fetch_stall, 1'b1);
    LoadIR = 1'b0;
    PCWrite = 1'b1; pc_in = 64'h8; tick(); idle_inputs();
    settle();
    chk("mis_clear", fetch_fault, 1'b0);
    chk("mis_req", imem_req, 1'b1);
    chk("mis_addr", imem_addr, 64'h8);
`else
    PCWrite = 1'b1; pc_in = 64'h6; tick(); idle_inputs();
    settle();
    chk("nomis_req", imem_req, 1'b1);
    chk("nomis_addr", imem_addr, 64'h6);
    tick();
    chk("nomis_fault", fetch_fault, 1'b0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
